dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, SHALL set the number of 32-bit words stored; it SHALL be a power of two, minimum 4.
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the wait states between request accept and response; the legal range SHALL be 0..15.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 mem_bus  mem_bus_if.periph  -  SHALL be the peripheral end of the memory bus, carrying req (in), we (in), addr[31:0] (in), wd[31:0] (in), rd[31:0] (out) and ready (out).
REQ-006 fault  output  1  SHALL flag an access rejected by the alignment check.
REQ-007 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-009 IDLE: req=1 SHALL latch we, addr and wd; the FSM SHALL go to WAIT if WAIT_CYCLES>0, otherwise straight to RESP.
REQ-010 WAIT: a 4-bit down-counter SHALL load WAIT_CYCLES-1 on entry and decrement each cycle; at count 0 the FSM SHALL go to RESP.
REQ-011 RESP: ready SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-012 Latency from the req-sampling edge to ready high SHALL be WAIT_CYCLES+1 cycles.
REQ-013 Writes SHALL commit to the array at the RESP edge, using word index addr[log2(DEPTH_WORDS)+1:2].
REQ-014 Reads: rd SHALL hold the addressed word while ready=1 and 0 otherwise.
REQ-015 In RESP, a write followed by a read of the same word SHALL return the new data.
REQ-016 req while busy SHALL be ignored; the initiator SHALL hold req until it sees ready.
REQ-017 When req is still high in the cycle after RESP, it SHALL be accepted as a new transaction, giving one transaction per WAIT_CYCLES+2 cycles.
REQ-018 Address bits above the index range SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-019 Changes to addr, we or wd after acceptance SHALL have no effect on the current transaction.

Reset
REQ-020 While rst=0 at a clock edge: the FSM SHALL go to IDLE, the counter SHALL clear, and ready, rd, fault and busy SHALL be 0 on the next cycle.
REQ-021 Reset during WAIT or RESP SHALL abort the transaction with no array write and no ready pulse.
REQ-022 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-023 With DMEM_ALIGN_CHECK_EN defined, an accepted request with addr[1:0]!=0 SHALL follow the normal timing, suppress the write, drive rd=0 and assert fault together with ready for that one cycle.
REQ-024 Without DMEM_ALIGN_CHECK_EN, fault SHALL be tied to 0 and addr[1:0] SHALL be ignored.

Structure
REQ-025 Package lib_cpu SHALL hold the state enum MEM_STATE (IDLE, WAIT, RESP) and the constant MEM_WAIT_MAX=15.
REQ-026 The array SHALL be a sub-module, dmem_array: one synchronous write port (clk, we, waddr, wd) and one combinational read port (raddr, rd).
REQ-027 The FSM, counter and request latches SHALL live in dmem_responder.

Verification
REQ-028 WAIT_CYCLES=2: write 0xDEADBEEF to 0x10, then read 0x10 -> ready on the 3rd cycle after req is sampled, rd=0xDEADBEEF.
REQ-029 WAIT_CYCLES=0: req held high across back-to-back reads -> ready every 2nd cycle, busy toggling.
REQ-030 DEPTH_WORDS=64: write 0x1 to 0x100, then read 0x0 -> rd=0x1 (wrap).
REQ-031 Write to 0x20 with rst=0 asserted in WAIT -> no ready pulse; a later read of 0x20 returns the old value.
REQ-032 DMEM_ALIGN_CHECK_EN defined: write to 0x13 -> fault=1 and ready=1 in the same cycle; the word at 0x10 is unchanged.
REQ-033 addr and wd changed one cycle after acceptance -> the original addr and wd are used.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and wait-state limit.
// Latency: n/a (types only). Backpressure: n/a.
// Imported by dmem_responder.
package lib_cpu;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } MEM_STATE;

    localparam int unsigned MEM_WAIT_MAX  = 15;
    localparam int unsigned MEM_WORD_BITS = 32;

    // Word index width for a power-of-two word count.
    function automatic int unsigned mem_idx_bits(input int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Memory bus between an initiator and a data-memory peripheral.
// Latency: set by the peripheral. Backpressure: initiator holds req until ready.
// master drives the request, periph returns rd/ready.
interface mem_bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;

    modport master (
        output req, we, addr, wd,
        input  rd, ready
    );

    modport periph (
        input  req, we, addr, wd,
        output rd, ready
    );
endinterface

// File: rtl/dmem_responder_array.sv
// Word storage for dmem_responder: one synchronous write port, one combinational read port.
// Latency: write visible the cycle after the write edge; read is same-cycle.
// Backpressure: none, always accepts.
module dmem_array #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wd,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rd
);

    // Contents deliberately survive reset.
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wd;
        end
    end

    assign rd = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one request, waits WAIT_CYCLES, answers with a one-cycle ready.
// Latency: WAIT_CYCLES+1 cycles from req sample to ready; one transaction per WAIT_CYCLES+2 cycles.
// Backpressure: req ignored while busy; initiator holds req until ready. Option: DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import lib_cpu::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst,
    mem_bus_if.periph mem_bus,
    output logic      fault,
    output logic      busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_RESP = RESP;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of two, at least 4");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > int'(MEM_WAIT_MAX)) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES out of range 0..15");
    end

    logic [1:0]    state_q;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic          mis_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wd_q;

    logic          accept;
    logic          mis_d;
    logic          resp;
    logic          arr_we;
    logic [31:0]   arr_rd;
    logic          unused_addr_bits;

    assign accept = (state_q == ST_IDLE) && mem_bus.req;

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_d = (mem_bus.addr[1:0] != 2'b00);
`else
    assign mis_d = 1'b0;
`endif

    // Bits outside the word index only wrap the address space.
    assign unused_addr_bits = ^{mem_bus.addr[31:AW+2], mem_bus.addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_bus.req) begin
                        state_q <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                        cnt_q   <= WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Request snapshot: later bus changes cannot disturb the transaction in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q  <= mem_bus.we;
            mis_q <= mis_d;
            idx_q <= mem_bus.addr[AW+1:2];
            wd_q  <= mem_bus.wd;
        end
    end

    // A reset arriving in RESP suppresses both the ready pulse and the write.
    assign resp   = (state_q == ST_RESP) && rst;
    assign arr_we = resp && we_q && !mis_q;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (idx_q),
        .wd    (wd_q),
        .raddr (idx_q),
        .rd    (arr_rd)
    );

    assign mem_bus.ready = resp;
    assign mem_bus.rd    = (resp && !we_q && !mis_q) ? arr_rd : 32'd0;
    assign fault         = resp && mis_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=2 and 0) checked against a word-array model.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_v;
    logic [1:0]  we_v;
    logic [31:0] addr_v [2];
    logic [31:0] wd_v   [2];
    logic [31:0] rd_v   [2];
    logic [1:0]  ready_v;
    logic [1:0]  fault_v;
    logic [1:0]  busy_v;
    logic        fault_a, fault_b, busy_a, busy_b;

    mem_bus_if bus_a ();
    mem_bus_if bus_b ();

    assign bus_a.req  = req_v[0];
    assign bus_a.we   = we_v[0];
    assign bus_a.addr = addr_v[0];
    assign bus_a.wd   = wd_v[0];
    assign bus_b.req  = req_v[1];
    assign bus_b.we   = we_v[1];
    assign bus_b.addr = addr_v[1];
    assign bus_b.wd   = wd_v[1];
    assign rd_v[0]    = bus_a.rd;
    assign rd_v[1]    = bus_b.rd;
    assign ready_v    = {bus_b.ready, bus_a.ready};
    assign fault_v    = {fault_b, fault_a};
    assign busy_v     = {busy_b, busy_a};

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .mem_bus(bus_a), .fault(fault_a), .busy(busy_a)
    );
    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .mem_bus(bus_b), .fault(fault_b), .busy(busy_b)
    );

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    int          nerr = 0;
    int          nchk = 0;
    int          wc [2] = '{2, 0};
    logic [31:0] model [2][64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the idle cycle following ready.
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] data,
                       input bit scramble, input string tag);
        int          n;
        int          idx;
        bit          mis;
        logic [31:0] exp_rd;
        idx    = int'((a % 32'd256) / 32'd4);
        mis    = ALIGN && ((a % 32'd4) != 32'd0);
        exp_rd = (w || mis) ? 32'h0 : model[d][idx];
        req_v[d]  = 1'b1;
        we_v[d]   = w;
        addr_v[d] = a;
        wd_v[d]   = data;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scramble && n == 1) begin
                addr_v[d] = ~a;
                wd_v[d]   = ~data;
                we_v[d]   = ~w;
            end
            chk({tag, " busy"}, 32'(busy_v[d]), 32'd1);
        end while (!ready_v[d] && n < 40);
        req_v[d] = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'(wc[d] + 1));
        chk({tag, " fault"}, 32'(fault_v[d]), 32'(mis));
        if (!w) chk({tag, " rd"}, rd_v[d], exp_rd);
        if (w && !mis) model[d][idx] = data;
        @(negedge clk);
        chk({tag, " ready drop"}, 32'(ready_v[d]), 32'd0);
        chk({tag, " idle"}, 32'(busy_v[d]), 32'd0);
    endtask

    initial begin
        #600000;
        $error("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, data;
        int          d;
        bit          w;

        rst    = 1'b0;
        req_v  = 2'b00;
        we_v   = 2'b00;
        addr_v = '{32'h0, 32'h0};
        wd_v   = '{32'h0, 32'h0};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset ready", 32'(ready_v[i]), 32'd0);
            chk("reset rd",    rd_v[i],          32'd0);
            chk("reset fault", 32'(fault_v[i]), 32'd0);
            chk("reset busy",  32'(busy_v[i]),  32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 64; k++)
                txn(i, 1'b1, 32'(k * 4), $urandom, 1'b0, "init");

        // Basic write then read with two wait states.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "wr 0x10");
        txn(0, 1'b0, 32'h10, 32'h0,        1'b0, "rd 0x10");

        // Wrap: 0x100 aliases word 0.
        txn(0, 1'b1, 32'h100, 32'h1, 1'b0, "wr 0x100");
        txn(0, 1'b0, 32'h0,   32'h0, 1'b0, "rd 0x0 wrap");
        txn(1, 1'b1, 32'hFFFF_FF04, 32'h5A5A_0001, 1'b0, "wr hi wrap");
        txn(1, 1'b0, 32'h4,   32'h0, 1'b0, "rd 0x4 wrap");

        // Bus changes after acceptance.
        txn(0, 1'b1, 32'h30, 32'h1234_5678, 1'b1, "wr scrambled");
        txn(0, 1'b0, 32'h30, 32'h0,         1'b1, "rd scrambled");
        txn(1, 1'b1, 32'h34, 32'h8765_4321, 1'b1, "wr0 scrambled");
        txn(1, 1'b0, 32'h34, 32'h0,         1'b0, "rd0 scrambled");

        // Reset in WAIT aborts the write.
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wd_v[0] = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("abort in wait", 32'(busy_v[0]), 32'd1);
        rst = 1'b0; req_v[0] = 1'b0;
        @(negedge clk);
        chk("abort ready", 32'(ready_v[0]), 32'd0);
        chk("abort busy",  32'(busy_v[0]),  32'd0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort no pulse", 32'(ready_v[0]), 32'd0);
        end
        txn(0, 1'b0, 32'h20, 32'h0, 1'b0, "rd 0x20 old");

        // Reset in RESP (zero-wait instance) kills the pulse and the write.
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h24; wd_v[1] = 32'hBAD1_BAD1;
        @(negedge clk);
        rst = 1'b0; req_v[1] = 1'b0;
        #1;
        chk("abort resp ready", 32'(ready_v[1]), 32'd0);
        @(negedge clk);
        chk("abort resp busy", 32'(busy_v[1]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        txn(1, 1'b0, 32'h24, 32'h0, 1'b0, "rd 0x24 old");

        // Zero-wait back-to-back reads with req held high.
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'h40;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("b2b ready", 32'(ready_v[1]), 32'(k % 2));
            chk("b2b busy",  32'(busy_v[1]),  32'(k % 2));
            if (k % 2 == 1) chk("b2b rd", rd_v[1], model[1][16]);
        end
        req_v[1] = 1'b0;
        @(negedge clk);
        chk("b2b end", 32'(ready_v[1]), 32'd0);

        // Misaligned write: faults and is dropped with the check enabled, lands on 0x10 otherwise.
        txn(0, 1'b1, 32'h13, 32'hCAFE_F00D, 1'b0, "wr 0x13");
        txn(0, 1'b0, 32'h10, 32'h0,         1'b0, "rd 0x10 after 0x13");
        txn(1, 1'b0, 32'h42, 32'h0,         1'b0, "rd 0x42");

        for (int k = 0; k < 60; k++) begin
            d    = int'($urandom_range(1, 0));
            w    = 1'($urandom_range(1, 0));
            a    = $urandom;
            data = $urandom;
            if ($urandom_range(3, 0) != 0) a = a & 32'hFFFF_FFFC;
            txn(d, w, a, data, 1'($urandom_range(1, 0)), w ? "rand wr" : "rand rd");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
